switch_conditioner: RTL and testbench
=====================================

# switch_conditioner

- Sits between the 16 board slide switches and the `catch_the_light` game core.
- Per switch, it synchronises the raw input to `clk` and debounces it with a consecutive-sample counter.
- It emits a stable level plus one-cycle rise/fall pulses, so the core scores exactly one event per physical flip.
- A `hold` input suppresses event pulses once the round timer has expired.

## Interface

Parameters:
- `WIDTH`, 16, number of switch lanes
- `DEBOUNCE_CYCLES`, 1000000, consecutive agreeing samples needed to accept a new level (10 ms at 100 MHz); legal range ≥ 2
- `CNT_W`, derived localparam, `$clog2(DEBOUNCE_CYCLES)`; not user-set

Ports:
- `clk` input 1: system clock, the same clock that drives the game core
- `reset` input 1: asynchronous, active-high; clears all state
- `sw_raw` input WIDTH: raw switch pins, asynchronous to `clk`
- `hold` input 1: synchronous to `clk`; high forces all event pulses to 0; driven by `timer_time_up`
- `sw_stable` output WIDTH: debounced switch levels
- `sw_rise` output WIDTH: one-cycle pulse per lane on an accepted 0→1 change
- `sw_fall` output WIDTH: one-cycle pulse per lane on an accepted 1→0 change
- `any_rise` output 1: registered OR of the per-lane rise conditions

## Operation

Each lane is independent and identical. Lanes share no state.
- **Synchroniser:**
  - Two flops per lane, `sync1` then `sync2`, both resetting to 0.
  - Only `sync2` feeds the debouncer.
- **Debounce counter** (CNT_W bits, per lane), evaluated at each edge:
  - If `sync2 == sw_stable`: counter is set to 0.
  - If `sync2 != sw_stable` and counter < DEBOUNCE_CYCLES-1: counter increments.
  - If `sync2 != sw_stable` and counter == DEBOUNCE_CYCLES-1: `sw_stable` takes `sync2` and the counter is set to 0.
- **Bounce rejection:**
  - Any sample agreeing with `sw_stable` restarts the count.
  - A bounce shorter than DEBOUNCE_CYCLES samples never changes `sw_stable`.
  - The counter never wraps.
- **Edge pulses:**
  - Registered at the same edge that updates `sw_stable`.
  - `sw_rise[i]` = 1 for exactly one cycle when lane i's stable level goes 0→1 and `hold` is 0 at that edge.
  - `sw_fall[i]` behaves the same way for a 1→0 change.
  - `any_rise` is registered from the same rise conditions, so it is aligned with `sw_rise`.
- **Hold:**
  - `sw_stable` keeps tracking regardless of `hold`.
  - Edges accepted while `hold` = 1 are discarded and never replayed after `hold` falls.
- **Simultaneous events:** several lanes may pulse in the same cycle; no arbitration.
- **Reset values:** `sync1`, `sync2`, counters, `sw_stable`, `sw_rise`, `sw_fall` and `any_rise` are all 0.
- **Reset mid-operation:**
  - Everything clears immediately; pending counts are lost.
  - A switch held high through reset produces one `sw_rise` after the full latency, unless `hold` = 1 at that edge. The game core treats this as a legal event.

## Timing

- Raw change captured into `sync1` at edge k:
  - `sync2` updates at edge k+1.
  - `sw_stable` and the matching pulse update at edge k+DEBOUNCE_CYCLES+1.
- Pulse width: exactly 1 clock. A lane cannot pulse again for at least DEBOUNCE_CYCLES cycles.
- `hold` is sampled at the update edge only, with no internal delay.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration

Macro `SW_COND_FALL_DETECT_EN`:
- **Defined:** `sw_fall` is generated as specified.
- **Undefined:**
  - `sw_fall` is tied to 0 and its registers are removed.
  - `sw_stable`, `sw_rise` and `any_rise` are unchanged.
  - This is the game's default build, since only catches (rises) score.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4 and WIDTH=16.

1. **Reset:** assert `reset` mid-count with `sw_raw`=16'hFFFF → all outputs 0 immediately. Release → `sw_stable`=16'hFFFF exactly 5 edges after the first capture edge, `sw_rise`=16'hFFFF for one cycle, `any_rise`=1.
2. **Clean rise:** `sw_raw[3]` 0→1 before edge k → `sw_stable[3]`=1 and `sw_rise[3]`=1 after edge k+5. `sw_rise[3]`=0 after edge k+6. No other lane changes.
3. **Bounce:** `sw_raw[7]` toggles 1,0,1,0 with 3-cycle high runs, then holds 1 → no pulse during the bounce. Exactly one `sw_rise[7]`, 5 edges after the final capture.
4. **Hold:** `hold`=1 while `sw_raw[0]` rises → `sw_stable[0]`=1 with no `sw_rise[0]`. Drop `hold` → still no pulse.
5. **Fall, macro defined:** `sw_raw[0]` then returns 1→0 → one `sw_fall[0]` pulse. With the macro undefined, `sw_fall` stays 16'h0000 throughout.
6. **Simultaneous:** lanes 2 and 15 rise in the same cycle → `sw_rise`=16'h8004 for one cycle and `any_rise`=1 in that same cycle.

Source files
------------

// File: rtl/switch_conditioner.sv
// Purpose: per-lane 2-flop synchroniser + consecutive-sample debouncer with registered rise/fall pulses for the board slide switches.
// Latency: a raw change sampled into sync1 at edge k appears on sw_stable and the pulse outputs at edge k+DEBOUNCE_CYCLES+1.
// Backpressure: none; the block is free-running, and 'hold' only suppresses pulses. Optional macro SW_COND_FALL_DETECT_EN enables sw_fall.
module switch_conditioner #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic             hold,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             any_rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    // Terminal count: the DEBOUNCE_CYCLES-th consecutive disagreeing sample is accepted.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic             any_rise_q, any_rise_d;
    logic [WIDTH-1:0] accept;

    // Debounce: count consecutive samples differing from the stable level; accept on the terminal count.
    always_comb begin
        sync1_d  = sw_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        accept   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                    accept[i]   = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        // Edges accepted under hold are dropped for good; sw_stable still follows.
        rise_d     = accept & sync2_q & {WIDTH{~hold}};
        any_rise_d = |rise_d;
    end

    // State registers: synchroniser, counters, stable level and rise pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            rise_q     <= '0;
            any_rise_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stable_q   <= stable_d;
            rise_q     <= rise_d;
            any_rise_q <= any_rise_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef SW_COND_FALL_DETECT_EN
    logic [WIDTH-1:0] fall_q, fall_d;

    // Fall pulse: accepted 1->0 change with hold low.
    always_comb begin
        fall_d = accept & ~sync2_q & {WIDTH{~hold}};
    end

    // Fall pulse register, aligned with the rise pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fall_q <= '0;
        end else begin
            fall_q <= fall_d;
        end
    end

    assign sw_fall = fall_q;
`else
    // Only catches score in the default build, so no fall registers exist.
    assign sw_fall = '0;
`endif

    assign sw_stable = stable_q;
    assign sw_rise   = rise_q;
    assign any_rise  = any_rise_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner with DEBOUNCE_CYCLES=4, WIDTH=16: directed scenarios with literal expectations
// followed by randomized switch, hold and reset activity, all checked every cycle against a run-length model.
// Outputs are sampled 1 time unit after the rising edge or at the falling edge; inputs change at the falling edge.
module tb_switch_conditioner;

    localparam int W  = 16;
    localparam int DC = 4;

`ifdef SW_COND_FALL_DETECT_EN
    localparam logic [W-1:0] FALL_LANE0 = 16'h0001;
    localparam bit           FALL_ON    = 1'b1;
`else
    localparam logic [W-1:0] FALL_LANE0 = 16'h0000;
    localparam bit           FALL_ON    = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] sw_raw = '0;
    logic         hold = 1'b0;
    logic [W-1:0] sw_stable, sw_rise, sw_fall;
    logic         any_rise;

    int n_cmp = 0;
    int n_bad = 0;

    switch_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .sw_raw    (sw_raw),
        .hold      (hold),
        .sw_stable (sw_stable),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .any_rise  (any_rise)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at time %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the debouncer sees the raw value from two edges earlier; a level is
    // accepted once DC consecutive seen samples disagree with the current stable level.
    logic [W-1:0] m_stable = '0;
    logic [W-1:0] m_rise   = '0;
    logic [W-1:0] m_fall   = '0;
    logic         m_any    = 1'b0;
    int           run [W];
    logic [W-1:0] delay_q [$] = '{16'h0000, 16'h0000};
    logic [W-1:0] seen;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_stable = '0;
            m_rise   = '0;
            m_fall   = '0;
            m_any    = 1'b0;
            for (int i = 0; i < W; i++) run[i] = 0;
            delay_q  = '{16'h0000, 16'h0000};
        end else begin
            seen = delay_q.pop_front();
            delay_q.push_back(sw_raw);
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < W; i++) begin
                if (seen[i] == m_stable[i]) begin
                    run[i] = 0;
                end else begin
                    run[i] = run[i] + 1;
                    if (run[i] == DC) begin
                        run[i]      = 0;
                        m_stable[i] = seen[i];
                        if (!hold) begin
                            if (seen[i]) m_rise[i] = 1'b1;
                            else         m_fall[i] = FALL_ON;
                        end
                    end
                end
            end
            m_any = |m_rise;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(posedge clk) begin
        #1;
        check("stable", sw_stable, m_stable);
        check("rise", sw_rise, m_rise);
        check("fall", sw_fall, m_fall);
        check("any_rise", {15'h0, any_rise}, {15'h0, m_any});
    end

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    int mode_noisy;

    initial begin
        for (int i = 0; i < W; i++) run[i] = 0;
        edges(2);
        reset = 1'b0;

        // Reset: mid-count reset clears everything; release with all switches high.
        sw_raw = 16'hFFFF;
        edges(3);
        reset = 1'b1;
        #1;
        check("rst_stable", sw_stable, 16'h0000);
        check("rst_rise", sw_rise, 16'h0000);
        check("rst_fall", sw_fall, 16'h0000);
        check("rst_any", {15'h0, any_rise}, 16'h0000);
        edges(2);
        reset = 1'b0;
        edges(5);
        check("rst_stable_k4", sw_stable, 16'h0000);
        edges(1);
        check("rst_stable_k5", sw_stable, 16'hFFFF);
        check("rst_rise_k5", sw_rise, 16'hFFFF);
        check("rst_any_k5", {15'h0, any_rise}, 16'h0001);
        edges(1);
        check("rst_rise_k6", sw_rise, 16'h0000);
        check("rst_any_k6", {15'h0, any_rise}, 16'h0000);

        // Clean rise on lane 3.
        sw_raw = 16'h0000;
        edges(8);
        check("clr_stable", sw_stable, 16'h0000);
        sw_raw = 16'h0008;
        edges(5);
        check("l3_rise_k4", sw_rise, 16'h0000);
        edges(1);
        check("l3_stable_k5", sw_stable, 16'h0008);
        check("l3_rise_k5", sw_rise, 16'h0008);
        edges(1);
        check("l3_rise_k6", sw_rise, 16'h0000);

        // Bounce on lane 7: 3-cycle high runs never qualify.
        for (int b = 0; b < 2; b++) begin
            sw_raw[7] = 1'b1;
            edges(3);
            sw_raw[7] = 1'b0;
            edges(2);
        end
        edges(3);
        check("bnc_stable", sw_stable, 16'h0008);
        sw_raw[7] = 1'b1;
        edges(5);
        check("bnc_rise_k4", sw_rise, 16'h0000);
        edges(1);
        check("bnc_rise_k5", sw_rise, 16'h0080);
        check("bnc_stable_k5", sw_stable, 16'h0088);
        edges(1);
        check("bnc_rise_k6", sw_rise, 16'h0000);

        // Hold suppresses the lane 0 rise; it is not replayed afterwards.
        hold = 1'b1;
        sw_raw[0] = 1'b1;
        edges(6);
        check("hold_stable", sw_stable, 16'h0089);
        check("hold_rise", sw_rise, 16'h0000);
        hold = 1'b0;
        edges(1);
        check("hold_rise_after", sw_rise, 16'h0000);
        edges(4);
        check("hold_any_after", {15'h0, any_rise}, 16'h0000);

        // Fall on lane 0.
        sw_raw[0] = 1'b0;
        edges(6);
        check("fall_k5", sw_fall, FALL_LANE0);
        check("fall_stable", sw_stable, 16'h0088);
        edges(1);
        check("fall_k6", sw_fall, 16'h0000);

        // Simultaneous rises on lanes 2 and 15.
        sw_raw = sw_raw | 16'h8004;
        edges(6);
        check("sim_rise", sw_rise, 16'h8004);
        check("sim_any", {15'h0, any_rise}, 16'h0001);
        check("sim_stable", sw_stable, 16'h808C);
        edges(1);
        check("sim_rise_after", sw_rise, 16'h0000);
        check("sim_any_after", {15'h0, any_rise}, 16'h0000);

        // Randomized phase: alternating quiet/noisy periods, random hold, occasional reset.
        mode_noisy = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ((c % 64) == 0) mode_noisy = int'($urandom_range(0, 1));
            for (int i = 0; i < W; i++) begin
                if (mode_noisy != 0) begin
                    if ($urandom_range(0, 2) == 0) sw_raw[i] = ~sw_raw[i];
                end else begin
                    if ($urandom_range(0, 47) == 0) sw_raw[i] = ~sw_raw[i];
                end
            end
            if ($urandom_range(0, 31) == 0) hold = ~hold;
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 699) == 0) reset = 1'b1;
        end
        reset = 1'b0;
        edges(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
